// File: rtl/trace_recorder.sv
// trace_recorder
//   Capture side of the I/O trace path. Samples a DUT I/O snapshot on cycles
//   marked valid and stamps it with a free-running cycle count. Each sample is
//   buffered in an on-chip first-word-fall-through FIFO and streamed to the
//   host over a ready/valid channel.
//
// Ports
//   clock, reset         sole clock; synchronous active-high reset
//   arm                  pulse, IDLE -> ARMED (latches max_samples)
//   trigger              ARMED -> CAPTURE (trigger cycle is capture-eligible)
//   stop                 CAPTURE -> DRAIN (stop cycle is not captured)
//   max_samples          auto-stop sample limit, 0 = unlimited
//   in_valid, in_data    snapshot tap
//   out_valid, out_ready head handshake toward the host
//   out_data, out_cycle  head snapshot and its cycle stamp
//   state                0 IDLE, 1 ARMED, 2 CAPTURE, 3 DRAIN
//   sample_count         samples pushed since arm
//   drop_count           samples lost to a full FIFO since arm (saturating)
//   done                 one-cycle pulse on the DRAIN -> IDLE cycle
module trace_recorder #(
  parameter int DATA_W  = 64,
  parameter int CYCLE_W = 64,
  parameter int DEPTH   = 256,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               arm,
  input  logic               trigger,
  input  logic               stop,
  input  logic [CNT_W-1:0]   max_samples,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CYCLE_W-1:0] out_cycle,
  output logic [1:0]         state,
  output logic [CNT_W-1:0]   sample_count,
  output logic [CNT_W-1:0]   drop_count,
  output logic               done
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = CYCLE_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic [EW-1:0]      mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r, rd_ptr_r;
  logic [AW:0]        count_r, count_s;
  logic [CYCLE_W-1:0] cycle_r;
  logic [CNT_W-1:0]   sample_count_r, drop_count_r, max_r;
  logic               out_valid_r, done_r;
  logic               capture_s, push_s, accept_s, drop_s, pop_s, arm_s, hit_max_s;

  // Datapath qualifiers: which cycles capture, whether a push fits, pops.
  always_comb begin
    pop_s     = out_valid_r & out_ready;
    // The trigger cycle captures even though the FSM is still in ARMED.
    capture_s = ((state_r == S_CAPTURE) & ~stop) | ((state_r == S_ARMED) & trigger);
    push_s    = capture_s & in_valid;
    // Space is judged on the registered count only; a same-cycle pop does not help.
    accept_s  = push_s & (count_r < (AW + 1)'(DEPTH));
    drop_s    = push_s & ~accept_s;
    hit_max_s = accept_s & (max_r != {CNT_W{1'b0}}) &
                ((sample_count_r + CNT_W'(1)) == max_r);
    case ({accept_s, pop_s})
      2'b10:   count_s = count_r + (AW + 1)'(1);
      2'b01:   count_s = count_r - (AW + 1)'(1);
      default: count_s = count_r;
    endcase
  end

  // Next-state logic for the capture FSM.
  always_comb begin
    state_s = state_r;
    arm_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (arm) begin
          state_s = S_ARMED;
          arm_s   = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ARMED: begin
        if (trigger) begin
          state_s = hit_max_s ? S_DRAIN : S_CAPTURE;
        end else begin
          state_s = S_ARMED;
        end
      end
      S_CAPTURE: begin
        if (stop || hit_max_s) begin
          state_s = S_DRAIN;
        end else begin
          state_s = S_CAPTURE;
        end
      end
      S_DRAIN: begin
        if (count_r == {(AW + 1){1'b0}}) begin
          state_s = S_IDLE;
        end else begin
          state_s = S_DRAIN;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // FSM state, FIFO pointers/occupancy, cycle counter and registered flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= S_IDLE;
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= {(AW + 1){1'b0}};
      cycle_r     <= {CYCLE_W{1'b0}};
      out_valid_r <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      wr_ptr_r    <= accept_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_r    <= pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
      count_r     <= count_s;
      cycle_r     <= cycle_r + CYCLE_W'(1);
      out_valid_r <= (count_s != {(AW + 1){1'b0}});
      // done marks the DRAIN cycle in which the FIFO is empty, i.e. the exit cycle.
      done_r      <= (state_s == S_DRAIN) & (count_s == {(AW + 1){1'b0}});
    end
  end

  // Per-arm statistics and the latched sample limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      sample_count_r <= {CNT_W{1'b0}};
      drop_count_r   <= {CNT_W{1'b0}};
      max_r          <= {CNT_W{1'b0}};
    end else if (arm_s) begin
      sample_count_r <= {CNT_W{1'b0}};
      drop_count_r   <= {CNT_W{1'b0}};
      max_r          <= max_samples;
    end else begin
      if (accept_s) begin
        sample_count_r <= sample_count_r + CNT_W'(1);
      end
      if (drop_s && (drop_count_r != {CNT_W{1'b1}})) begin
        drop_count_r <= drop_count_r + CNT_W'(1);
      end
    end
  end

  // Sample storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clock) begin
    if (accept_s) begin
      mem_r[wr_ptr_r] <= {cycle_r, in_data};
    end
  end

  assign {out_cycle, out_data} = mem_r[rd_ptr_r];
  assign out_valid    = out_valid_r;
  assign state        = state_r;
  assign sample_count = sample_count_r;
  assign drop_count   = drop_count_r;
  assign done         = done_r;

endmodule

// File: tb/tb_trace_recorder.sv
// tb_trace_recorder
//   Self-checking bench for trace_recorder with a small FIFO (DEPTH=4).
//   A queue-based reference model follows the recorder's rules cycle by cycle.
//   The host side is observed by collecting every accepted head into a list.
module tb_trace_recorder;
  localparam int DW = 32, CW = 32, DEPTH = 4, NW = 16;

  logic clock = 1'b0;
  logic reset, arm, trigger, stop, in_valid, out_ready;
  logic [NW-1:0] max_samples;
  logic [DW-1:0] in_data;
  logic out_valid, done;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_cycle;
  logic [1:0] state;
  logic [NW-1:0] sample_count, drop_count;

  always #5 clock = ~clock;

  trace_recorder #(.DATA_W(DW), .CYCLE_W(CW), .DEPTH(DEPTH), .CNT_W(NW)) dut (
    .clock(clock), .reset(reset), .arm(arm), .trigger(trigger), .stop(stop),
    .max_samples(max_samples), .in_valid(in_valid), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cycle(out_cycle), .state(state), .sample_count(sample_count),
    .drop_count(drop_count), .done(done));

  typedef struct packed { logic [CW-1:0] cyc; logic [DW-1:0] dat; } ent_t;

  // reference model
  ent_t mq[$];
  ent_t m_hist[$];
  int m_state;
  logic [NW-1:0] m_scount, m_dcount, m_max;
  logic [CW-1:0] m_cycle;

  // observations
  ent_t popped[$];
  logic [CW-1:0] last_pop, done_cyc;
  int done_cnt;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] sent[$];

  task automatic tick();
    int sz;
    bit pop, push, acc;
    ent_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      popped.push_back({out_cycle, out_data});
      last_pop = m_cycle;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = m_cycle;
    end
    if (reset) begin
      mq.delete();
      m_state = 0; m_scount = '0; m_dcount = '0; m_max = '0; m_cycle = '0;
    end else begin
      sz = mq.size();
      pop = (sz != 0) && out_ready;
      push = in_valid && ((m_state == 2 && !stop) || (m_state == 1 && trigger));
      acc = push && (sz < DEPTH);
      if (pop) void'(mq.pop_front());
      if (acc) begin
        e = {m_cycle, in_data};
        mq.push_back(e);
        m_hist.push_back(e);
        m_scount++;
      end else if (push && m_dcount != {NW{1'b1}}) begin
        m_dcount++;
      end
      case (m_state)
        0: if (arm) begin m_state = 1; m_scount = '0; m_dcount = '0; m_max = max_samples; end
        1: if (trigger) m_state = (acc && m_max != 0 && m_scount == m_max) ? 3 : 2;
        2: if (stop || (acc && m_max != 0 && m_scount == m_max)) m_state = 3;
        3: if (sz == 0) m_state = 0;
        default: m_state = 0;
      endcase
      m_cycle++;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic rst();
    reset = 1'b1; arm = 1'b0; trigger = 1'b0; stop = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; max_samples = '0; in_data = '0;
    tick(); tick();
    reset = 1'b0;
    popped.delete(); m_hist.delete(); sent.delete();
    done_cnt = 0;
  endtask

  task automatic do_arm(input logic [NW-1:0] mx);
    max_samples = mx; arm = 1'b1; tick(); arm = 1'b0; max_samples = '0;
  endtask

  // n valid pushes, trigger asserted in the first one
  task automatic push_burst(input int n);
    trigger = 1'b1;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1; in_data = $urandom; sent.push_back(in_data);
      tick(); trigger = 1'b0;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst();
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (sample_count !== '0) begin n_bad++; $display("FAIL reset_sample_count: got %0d want 0", sample_count); end
    n_cmp++; if (drop_count !== '0) begin n_bad++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
    repeat (3) tick();
    n_cmp++; if (done_cnt != 0) begin n_bad++; $display("FAIL reset_done: got %0d pulses want 0", done_cnt); end
  endtask

  task automatic test_basic();
    rst();
    out_ready = 1'b1;
    tick(); tick();          // cycles 0,1
    do_arm('0);              // cycle 2
    repeat (7) tick();       // cycles 3..9
    push_burst(5);           // cycles 10..14
    stop = 1'b1; tick(); stop = 1'b0;
    repeat (8) tick();
    n_cmp++; if (popped.size() != 5) begin n_bad++; $display("FAIL basic_count: got %0d want 5", popped.size()); end
    for (int i = 0; i < 5 && i < popped.size(); i++) begin
      n_cmp++;
      if (popped[i].cyc !== CW'(10 + i) || popped[i].dat !== sent[i]) begin
        n_bad++;
        $display("FAIL basic_sample%0d: got cyc %0d data %h want cyc %0d data %h",
                 i, popped[i].cyc, popped[i].dat, 10 + i, sent[i]);
      end
    end
    n_cmp++; if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done_pulses: got %0d want 1", done_cnt); end
    n_cmp++; if (done_cyc !== CW'(16) || last_pop !== CW'(15)) begin
      n_bad++; $display("FAIL basic_done_time: got done %0d last pop %0d want 16/15", done_cyc, last_pop);
    end
    n_cmp++; if (state !== 2'd0) begin n_bad++; $display("FAIL basic_state: got %0d want 0", state); end
  endtask

  task automatic test_overflow();
    rst();
    do_arm('0);
    push_burst(7);
    stop = 1'b1; tick(); stop = 1'b0;
    n_cmp++; if (sample_count !== NW'(4)) begin n_bad++; $display("FAIL ovf_sample_count: got %0d want 4", sample_count); end
    n_cmp++; if (drop_count !== NW'(3)) begin n_bad++; $display("FAIL ovf_drop_count: got %0d want 3", drop_count); end
    n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL ovf_state: got %0d want 3", state); end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== sent[0]) begin
      n_bad++; $display("FAIL ovf_head: got v%b %h want v1 %h", out_valid, out_data, sent[0]);
    end
    out_ready = 1'b1;
    repeat (8) tick();
    n_cmp++; if (popped.size() != 4) begin n_bad++; $display("FAIL ovf_drained: got %0d want 4", popped.size()); end
    for (int i = 0; i < 4 && i < popped.size(); i++) begin
      n_cmp++;
      if (popped[i].dat !== sent[i] || popped[i] !== m_hist[i]) begin
        n_bad++; $display("FAIL ovf_sample%0d: got %h want %h", i, popped[i], {m_hist[i].cyc, sent[i]});
      end
    end
    n_cmp++; if (done_cnt != 1 || state !== 2'd0) begin
      n_bad++; $display("FAIL ovf_end: got done %0d state %0d want 1/0", done_cnt, state);
    end
  endtask

  task automatic test_max();
    rst();
    do_arm(NW'(3));
    trigger = 1'b1; in_valid = 1'b1; in_data = $urandom;
    for (int i = 0; i < 3; i++) begin
      tick(); trigger = 1'b0; in_data = $urandom;
    end
    n_cmp++; if (state !== 2'd3) begin n_bad++; $display("FAIL max_state: got %0d want 3", state); end
    n_cmp++; if (sample_count !== NW'(3)) begin n_bad++; $display("FAIL max_count: got %0d want 3", sample_count); end
    tick();
    n_cmp++; if (sample_count !== NW'(3) || drop_count !== '0) begin
      n_bad++; $display("FAIL max_after: got %0d/%0d want 3/0", sample_count, drop_count);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    n_cmp++; if (popped.size() != 3 || state !== 2'd0) begin
      n_bad++; $display("FAIL max_drain: got %0d samples state %0d want 3/0", popped.size(), state);
    end
  endtask

  task automatic test_full_pop();
    rst();
    do_arm('0);
    push_burst(4);
    in_valid = 1'b1; out_ready = 1'b1; in_data = $urandom;
    tick();
    n_cmp++; if (drop_count !== NW'(1) || sample_count !== NW'(4)) begin
      n_bad++; $display("FAIL full_counts: got %0d/%0d want 4/1", sample_count, drop_count);
    end
    n_cmp++; if (popped.size() != 1 || popped[0].dat !== sent[0]) begin
      n_bad++; $display("FAIL full_pop: got %0d pops want 1 of %h", popped.size(), sent[0]);
    end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== sent[1]) begin
      n_bad++; $display("FAIL full_head: got %h want %h", out_data, sent[1]);
    end
    // one slot must now be free: this push has to be accepted
    out_ready = 1'b0; in_data = $urandom; sent.push_back(in_data);
    tick();
    in_valid = 1'b0;
    n_cmp++; if (sample_count !== NW'(5) || drop_count !== NW'(1)) begin
      n_bad++; $display("FAIL full_refill: got %0d/%0d want 5/1", sample_count, drop_count);
    end
    stop = 1'b1; tick(); stop = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    n_cmp++; if (popped.size() != 5 || popped[popped.size()-1].dat !== sent[4]) begin
      n_bad++; $display("FAIL full_drain: got %0d samples want 5 ending %h", popped.size(), sent[4]);
    end
  endtask

  task automatic test_random();
    int sent_n = 0, cyc = 0;
    bit stall = 1'b0;
    logic [DW-1:0] pd;
    logic [CW-1:0] pc;
    rst();
    do_arm('0);
    trigger = 1'b1; tick(); trigger = 1'b0;
    while (sent_n < 100 && cyc < 3000) begin
      in_valid = ($urandom_range(0, 1) == 1) && (mq.size() < DEPTH);
      in_data = $urandom;
      out_ready = ($urandom_range(0, 1) == 1);
      if (stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== pd || out_cycle !== pc) begin
          n_bad++; $display("FAIL rand_stable: got v%b %h/%h want v1 %h/%h", out_valid, out_cycle, out_data, pc, pd);
        end
      end
      stall = out_valid && !out_ready;
      pd = out_data; pc = out_cycle;
      if (in_valid) sent_n++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_cmp++; if (sent_n != 100) begin n_bad++; $display("FAIL rand_budget: got %0d sent want 100", sent_n); end
    stop = 1'b1; tick(); stop = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 4) tick();
    n_cmp++; if (popped.size() != 100 || m_hist.size() != 100) begin
      n_bad++; $display("FAIL rand_total: got %0d want %0d (100)", popped.size(), m_hist.size());
    end
    for (int i = 0; i < popped.size() && i < m_hist.size(); i++) begin
      n_cmp++;
      if (popped[i] !== m_hist[i]) begin
        n_bad++; $display("FAIL rand_sample%0d: got %h want %h", i, popped[i], m_hist[i]);
      end
    end
    n_cmp++; if (drop_count !== '0 || sample_count !== m_scount || state !== 2'd0) begin
      n_bad++; $display("FAIL rand_end: got drop %0d cnt %0d state %0d want 0/%0d/0", drop_count, sample_count, state, m_scount);
    end
  endtask

  task automatic test_reset_capture();
    rst();
    do_arm('0);
    push_burst(3);
    arm = 1'b1; tick(); arm = 1'b0;
    n_cmp++; if (state !== 2'd2 || sample_count !== NW'(3)) begin
      n_bad++; $display("FAIL rc_arm_ignored: got state %0d cnt %0d want 2/3", state, sample_count);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || state !== 2'd0) begin
      n_bad++; $display("FAIL rc_flush: got v%b state %0d want 0/0", out_valid, state);
    end
    n_cmp++; if (sample_count !== '0 || drop_count !== '0) begin
      n_bad++; $display("FAIL rc_counters: got %0d/%0d want 0/0", sample_count, drop_count);
    end
    repeat (4) tick();
    n_cmp++; if (done_cnt != 0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL rc_no_done: got %0d pulses v%b want 0/0", done_cnt, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_max();
    test_full_pop();
    test_random();
    test_reset_capture();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
